// File: rtl/des_mode_pkg.sv
// Shared constants, types and helpers for the DES block-cipher mode sequencer.
package des_mode_pkg;

    localparam int unsigned DES_BLK_W = 64;

    typedef logic [DES_BLK_W-1:0] blk_t;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;
    localparam logic DIR_ENC  = 1'b0;
    localparam logic DIR_DEC  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic mode;
        logic dir;
        blk_t key;
    } cfg_t;

    // Conditional chaining XOR used on both the engine input and the result path.
    function automatic blk_t xor_if(input logic en, input blk_t a, input blk_t b);
        return en ? (a ^ b) : a;
    endfunction

endpackage

// File: rtl/des_mode_if.sv
// Configuration, block stream and des_core engine signals of the mode sequencer.
interface des_mode_if;

    logic                 cfg_load;
    logic                 cfg_mode;
    logic                 cfg_dir;
    des_mode_pkg::blk_t   cfg_key;
    des_mode_pkg::blk_t   cfg_iv;
    logic                 cfg_err;

    logic                 in_valid;
    des_mode_pkg::blk_t   in_data;
    logic                 in_ready;

    logic                 out_valid;
    des_mode_pkg::blk_t   out_data;
    logic                 out_ready;

    logic                 eng_encipher_en;
    logic                 eng_decipher_en;
    des_mode_pkg::blk_t   eng_data;
    des_mode_pkg::blk_t   eng_key;
    des_mode_pkg::blk_t   eng_result;
    logic                 eng_ready;

    // Sequencer side
    modport slave (
        input  cfg_load, cfg_mode, cfg_dir, cfg_key, cfg_iv,
        output cfg_err,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready,
        output eng_encipher_en, eng_decipher_en, eng_data, eng_key,
        input  eng_result, eng_ready
    );

    // Host, sink and engine side
    modport master (
        output cfg_load, cfg_mode, cfg_dir, cfg_key, cfg_iv,
        input  cfg_err,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready,
        input  eng_encipher_en, eng_decipher_en, eng_data, eng_key,
        output eng_result, eng_ready
    );

endinterface

// File: rtl/des_mode_ctrl_fifo.sv
// Synchronous block FIFO; pointers carry an extra wrap bit to tell full from empty.
module des_blk_fifo
    import des_mode_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  blk_t data_i,
    input  logic pop_i,
    output logic full_c,
    output logic empty_c,
    output blk_t head_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    blk_t          mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

    // Full blocks a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_c;
    assign do_pop  = pop_i && !empty_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/des_mode_ctrl.sv
// ECB/CBC mode sequencer feeding one block at a time into an external des_core.
module des_mode_ctrl
    import des_mode_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    des_mode_if.slave        bus,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);

    state_e           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    blk_t             chain_q, chain_d;
    blk_t             hold_q, hold_d;
    blk_t             eng_data_q, eng_data_d;
    blk_t             eng_key_q, eng_key_d;
    logic             enc_en_q, enc_en_d;
    logic             dec_en_q, dec_en_d;
    logic             out_valid_q, out_valid_d;
    blk_t             out_data_q, out_data_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q;

    logic             fifo_full;
    logic             fifo_empty;
    blk_t             fifo_head;
    logic             fifo_pop;
    logic             busy_c;
    logic             cbc_enc;
    logic             cbc_dec;
    logic             eng_done;

    des_blk_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.in_valid),
        .data_i  (bus.in_data),
        .pop_i   (fifo_pop),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .head_c  (fifo_head)
    );

    assign busy_c  = (state_q != ST_IDLE) || !fifo_empty || out_valid_q;
    assign cbc_enc = (cfg_q.mode == MODE_CBC) && (cfg_q.dir == DIR_ENC);
    assign cbc_dec = (cfg_q.mode == MODE_CBC) && (cfg_q.dir == DIR_DEC);

    // Rising edge of engine ready, never credited while the start pulse is still up.
    assign eng_done = bus.eng_ready && !rdy_q && !enc_en_q && !dec_en_q;

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        chain_d     = chain_q;
        hold_d      = hold_q;
        eng_data_d  = eng_data_q;
        eng_key_d   = eng_key_q;
        enc_en_d    = 1'b0;
        dec_en_d    = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cfg_err_d   = 1'b0;
        cnt_d       = cnt_q;
        fifo_pop    = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Reconfiguration only between streams; otherwise flag and drop it.
        if (bus.cfg_load) begin
            if (busy_c) begin
                cfg_err_d = 1'b1;
            end else begin
                cfg_d.mode = bus.cfg_mode;
                cfg_d.dir  = bus.cfg_dir;
                cfg_d.key  = bus.cfg_key;
                chain_d    = bus.cfg_iv;
                cnt_d      = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !out_valid_q) begin
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                fifo_pop   = 1'b1;
                eng_data_d = xor_if(cbc_enc, fifo_head, chain_q);
                eng_key_d  = cfg_q.key;
                enc_en_d   = (cfg_q.dir == DIR_ENC);
                dec_en_d   = (cfg_q.dir == DIR_DEC);
                hold_d     = fifo_head;
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                if (eng_done) begin
                    out_data_d  = xor_if(cbc_dec, bus.eng_result, chain_q);
                    out_valid_d = 1'b1;
                    // Encipher chains on ciphertext out, decipher on ciphertext in.
                    if (cfg_q.mode == MODE_CBC) begin
                        chain_d = (cfg_q.dir == DIR_ENC) ? bus.eng_result : hold_q;
                    end
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            chain_q     <= '0;
            hold_q      <= '0;
            eng_data_q  <= '0;
            eng_key_q   <= '0;
            enc_en_q    <= 1'b0;
            dec_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            chain_q     <= chain_d;
            hold_q      <= hold_d;
            eng_data_q  <= eng_data_d;
            eng_key_q   <= eng_key_d;
            enc_en_q    <= enc_en_d;
            dec_en_q    <= dec_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_err_q   <= cfg_err_d;
            cnt_q       <= cnt_d;
            rdy_q       <= bus.eng_ready;
        end
    end

    assign bus.in_ready        = !fifo_full;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign bus.cfg_err         = cfg_err_q;
    assign bus.eng_encipher_en = enc_en_q;
    assign bus.eng_decipher_en = dec_en_q;
    assign bus.eng_data        = eng_data_q;
    assign bus.eng_key         = eng_key_q;
    assign busy                = busy_c;
    assign blk_cnt             = cnt_q;

endmodule
